grayscale_pipe: RTL and testbench

Pipelined, parametrised RGB-to-grayscale converter for the canny front end. It sits between the input pixel FIFO and the downstream filter FIFO, in the same slot as the single-pixel grayscale stage. It sustains one pixel per clock and supports a runtime choice between channel mean and BT.601-style luma weighting. It also counts pixels per frame and flags the last pixel of each frame.

---
 rtl/grayscale_pkg.sv | 24 ++
 rtl/grayscale_weight.sv | 65 ++++++
 rtl/grayscale_pipe.sv | 95 +++++++++
 tb/tb_grayscale_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// Shared constants, mode type and width helpers for the grayscale pipeline.
package grayscale_pkg;

  // BT.601-style luma weights; they sum to 256 so the result is sum >> 8.
  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  typedef enum logic {
    GS_MEAN = 1'b0,
    GS_LUMA = 1'b1
  } gs_mode_e;

  function automatic int unsigned gs_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Sum register must hold either the channel sum or the weighted luma sum.
  function automatic int unsigned gs_sum_w(input int unsigned cw, input int unsigned nc);
    return gs_max(cw + $clog2(nc) + 1, cw + LUMA_SHIFT);
  endfunction

endpackage

// File: rtl/grayscale_weight.sv
// Combinational weighting: pixel -> sum (S1 side) and registered sum -> gray (S2 side).
module grayscale_weight
  import grayscale_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned NUM_CHANNELS  = 3,
  parameter int unsigned SUM_W         = gs_sum_w(CHANNEL_WIDTH, NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] pix,
  input  gs_mode_e                              mode,
  output logic [SUM_W-1:0]                      sum,
  output gs_mode_e                              sum_mode,
  input  logic [SUM_W-1:0]                      sum_q,
  input  gs_mode_e                              mode_q,
  output logic [CHANNEL_WIDTH-1:0]              result
);

  localparam int unsigned CW = CHANNEL_WIDTH;

  logic [SUM_W-1:0] mean_sum;
  logic [SUM_W-1:0] luma_sum;
  logic             luma_ok;

  // Zero-extended sum of every channel for mean mode
  always_comb begin
    mean_sum = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      mean_sum = mean_sum + SUM_W'(pix[i*CW +: CW]);
    end
  end

  // Luma only exists for RGB; other channel counts fall back to mean
  if (NUM_CHANNELS == 3) begin : g_luma
    logic [CW-1:0] ch_r;
    logic [CW-1:0] ch_g;
    logic [CW-1:0] ch_b;
    assign ch_r     = pix[2*CW +: CW];
    assign ch_g     = pix[CW +: CW];
    assign ch_b     = pix[0 +: CW];
    assign luma_sum = SUM_W'(LUMA_R) * SUM_W'(ch_r)
                    + SUM_W'(LUMA_G) * SUM_W'(ch_g)
                    + SUM_W'(LUMA_B) * SUM_W'(ch_b);
    assign luma_ok  = 1'b1;
  end else begin : g_no_luma
    assign luma_sum = '0;
    assign luma_ok  = 1'b0;
    $warning("grayscale_weight: NUM_CHANNELS != 3, luma mode falls back to mean");
  end

  // Pick the sum for the effective mode of this pixel
  always_comb begin
    sum_mode = (mode == GS_LUMA && luma_ok) ? GS_LUMA : GS_MEAN;
    sum      = (sum_mode == GS_LUMA) ? luma_sum : mean_sum;
  end

  // Scale the registered sum; luma max is exactly 2^CW-1 so no clamp
  always_comb begin
    if (mode_q == GS_LUMA) begin
      result = CW'(sum_q >> LUMA_SHIFT);
    end else begin
      result = CW'(sum_q / SUM_W'(NUM_CHANNELS));
    end
  end

endmodule

// File: rtl/grayscale_pipe.sv
// Two-stage RGB-to-grayscale pipeline between show-ahead input and output FIFOs,
// with a per-frame pixel counter and last-pixel flag.
module grayscale_pipe
  import grayscale_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned NUM_CHANNELS  = 3,
  parameter int unsigned FRAME_PIXELS  = 720*540
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  mode,
  output logic                                  in_rd_en,
  input  logic                                  in_empty,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] in_dout,
  output logic                                  out_wr_en,
  input  logic                                  out_full,
  output logic [CHANNEL_WIDTH-1:0]              out_din,
  output logic                                  frame_done,
  output logic [$clog2(FRAME_PIXELS)-1:0]       pixel_count
);

  localparam int unsigned CW    = CHANNEL_WIDTH;
  localparam int unsigned SUM_W = gs_sum_w(CHANNEL_WIDTH, NUM_CHANNELS);
  localparam int unsigned PC_W  = $clog2(FRAME_PIXELS);
  localparam int unsigned LAST  = FRAME_PIXELS - 1;

  logic             v1;
  logic             v2;
  logic [SUM_W-1:0] s1_sum;
  gs_mode_e         s1_mode;
  logic [CW-1:0]    s2_pix;

  logic             advance;
  logic             last_pix;
  logic [SUM_W-1:0] w_sum;
  gs_mode_e         w_mode;
  logic [CW-1:0]    w_result;

  grayscale_weight #(
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .NUM_CHANNELS  (NUM_CHANNELS),
    .SUM_W         (SUM_W)
  ) u_weight (
    .pix      (in_dout),
    .mode     (gs_mode_e'(mode)),
    .sum      (w_sum),
    .sum_mode (w_mode),
    .sum_q    (s1_sum),
    .mode_q   (s1_mode),
    .result   (w_result)
  );

  // Handshake: stall only when S2 holds a pixel the output cannot take.
  // Reset gates both strobes so nothing moves while reset is low.
  always_comb begin
    advance    = !(v2 && out_full);
    in_rd_en   = reset && !in_empty && advance;
    out_wr_en  = reset && v2 && !out_full;
    last_pix   = (pixel_count == PC_W'(LAST));
    frame_done = out_wr_en && last_pix;
    out_din    = s2_pix;
  end

  // Pipeline registers: both stages shift together on advance
  always_ff @(posedge clock) begin
    if (!reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s1_sum  <= '0;
      s1_mode <= GS_MEAN;
      s2_pix  <= '0;
    end else if (advance) begin
      v1 <= in_rd_en;
      if (in_rd_en) begin
        s1_sum  <= w_sum;
        s1_mode <= w_mode;
      end
      v2 <= v1;
      if (v1) begin
        s2_pix <= w_result;
      end
    end
  end

  // Frame pixel counter, wraps on the last pixel of a frame
  always_ff @(posedge clock) begin
    if (!reset) begin
      pixel_count <= '0;
    end else if (out_wr_en) begin
      pixel_count <= last_pix ? '0 : pixel_count + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Randomised and directed bench for grayscale_pipe against a queue-based model.
module tb_grayscale_pipe;

  localparam int unsigned CW    = 8;
  localparam int unsigned PW    = 24;
  localparam int unsigned FPA   = 4;
  localparam int unsigned FPB   = 720*540;
  localparam int unsigned PCA_W = $clog2(FPA);
  localparam int unsigned PCB_W = $clog2(FPB);

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic out_full = 1'b0;
  logic gap = 1'b0;
  logic mode;
  logic in_empty;
  logic [PW-1:0] in_dout;

  logic rd_a, wr_a, fd_a, rd_b, wr_b, fd_b;
  logic [CW-1:0] din_a, din_b;
  logic [PCA_W-1:0] pc_a;
  logic [PCB_W-1:0] pc_b;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  // Show-ahead source FIFO, popped by DUT A
  bit [PW-1:0] src_pix [8192];
  bit          src_mode[8192];
  int rd_ptr = 0;
  int wr_ptr = 0;
  logic [12:0] rd_idx;
  assign rd_idx   = 13'(rd_ptr);
  assign in_dout  = src_pix[rd_idx];
  assign mode     = src_mode[rd_idx];
  assign in_empty = (rd_ptr >= wr_ptr) || gap;
  always @(posedge clock) if (rd_a === 1'b1) rd_ptr <= rd_ptr + 1;

  grayscale_pipe #(.CHANNEL_WIDTH(8), .NUM_CHANNELS(3), .FRAME_PIXELS(FPA)) dut_a (
    .clock(clock), .reset(reset), .mode(mode), .in_rd_en(rd_a), .in_empty(in_empty),
    .in_dout(in_dout), .out_wr_en(wr_a), .out_full(out_full), .out_din(din_a),
    .frame_done(fd_a), .pixel_count(pc_a));

  grayscale_pipe #(.CHANNEL_WIDTH(8), .NUM_CHANNELS(3), .FRAME_PIXELS(FPB)) dut_b (
    .clock(clock), .reset(reset), .mode(mode), .in_rd_en(rd_b), .in_empty(in_empty),
    .in_dout(in_dout), .out_wr_en(wr_b), .out_full(out_full), .out_din(din_b),
    .frame_done(fd_b), .pixel_count(pc_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference gray value straight from the arithmetic definition
  function automatic logic [7:0] gray_of(input logic [23:0] p, input logic m);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (m) return 8'((77*r + 150*g + 29*b) / 256);
    return 8'((r + g + b) / 3);
  endfunction

  // Model: in-flight pixels with count of pipeline moves since pop
  typedef struct {
    logic [7:0] gray;
    int         moves;
  } item_t;
  item_t infl[$];
  int cnt_a = 0;
  int cnt_b = 0;
  int cyc = 0;

  logic [7:0] wr_log[$];
  logic       fd_log[$];
  int         pc_log[$];
  int         wr_cyc[$];
  int         pop_cyc[$];

  // Compare process: check at negedge, advance model at posedge
  always begin : compare
    logic head_ready, e_adv, e_wr, e_rd, s_reset, s_mode;
    logic [23:0] s_pix;
    item_t it;
    @(negedge clock);
    cyc++;
    head_ready = (infl.size() > 0) && (infl[0].moves >= 1);
    e_adv = !(head_ready && out_full);
    e_wr  = reset && !out_full && head_ready;
    e_rd  = reset && !in_empty && e_adv;
    chk("in_rd_en_a", 32'(rd_a), 32'(e_rd));
    chk("in_rd_en_b", 32'(rd_b), 32'(e_rd));
    chk("out_wr_en_a", 32'(wr_a), 32'(e_wr));
    chk("out_wr_en_b", 32'(wr_b), 32'(e_wr));
    chk("frame_done_a", 32'(fd_a), 32'(e_wr && cnt_a == int'(FPA) - 1));
    chk("frame_done_b", 32'(fd_b), 32'(e_wr && cnt_b == int'(FPB) - 1));
    chk("pixel_count_a", 32'(pc_a), 32'(cnt_a));
    chk("pixel_count_b", 32'(pc_b), 32'(cnt_b));
    if (e_wr) begin
      chk("out_din_a", 32'(din_a), 32'(infl[0].gray));
      chk("out_din_b", 32'(din_b), 32'(infl[0].gray));
    end
    if (wr_a === 1'b1) begin
      wr_log.push_back(din_a);
      fd_log.push_back(fd_a);
      pc_log.push_back(int'(pc_a));
      wr_cyc.push_back(cyc);
    end
    if (rd_a === 1'b1) pop_cyc.push_back(cyc);
    s_reset = reset;
    s_pix   = in_dout;
    s_mode  = mode;
    @(posedge clock);
    if (!s_reset) begin
      infl.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (e_wr) begin
        void'(infl.pop_front());
        cnt_a = (cnt_a + 1) % int'(FPA);
        cnt_b = (cnt_b + 1) % int'(FPB);
      end
      if (e_adv) for (int i = 0; i < infl.size(); i++) infl[i].moves = infl[i].moves + 1;
      if (e_rd) begin
        it.gray  = gray_of(s_pix, s_mode);
        it.moves = 0;
        infl.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [23:0] p, input logic m);
    src_pix[13'(wr_ptr)]  = p;
    src_mode[13'(wr_ptr)] = m;
    wr_ptr++;
  endtask

  task automatic clear_logs();
    wr_log.delete(); fd_log.delete(); pc_log.delete(); wr_cyc.delete(); pop_cyc.delete();
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    gap = 1'b0;
    out_full = 1'b0;
    while ((infl.size() != 0 || rd_ptr < wr_ptr) && n < limit) begin
      tick();
      n++;
    end
    chk({name, "_drain_in_time"}, 32'(n < limit), 32'd1);
  endtask

  function automatic logic [31:0] log_din(input int i);
    return (wr_log.size() > i) ? 32'(wr_log[i]) : 'x;
  endfunction
  function automatic logic [31:0] log_fd(input int i);
    return (fd_log.size() > i) ? 32'(fd_log[i]) : 'x;
  endfunction
  function automatic logic [31:0] log_pc(input int i);
    return (pc_log.size() > i) ? 32'(pc_log[i]) : 'x;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] held;
    logic [7:0] alt_exp;
    int n, pushed;

    // Reset state
    repeat (3) tick();
    chk("rst_out_din", 32'(din_a), 32'h0);
    chk("rst_pixel_count", 32'(pc_a), 32'h0);
    chk("rst_out_wr_en", 32'(wr_a), 32'h0);
    chk("rst_in_rd_en", 32'(rd_a), 32'h0);
    chk("rst_frame_done", 32'(fd_a), 32'h0);
    reset = 1'b1;
    tick();

    // Mean mode directed values, latency and throughput
    clear_logs();
    push(24'hFF0000, 1'b0); push(24'h010203, 1'b0); push(24'hFFFFFF, 1'b0);
    drain("mean", 50);
    chk("mean_writes", 32'(wr_log.size()), 32'd3);
    chk("mean_px0", log_din(0), 32'h55);
    chk("mean_px1", log_din(1), 32'h02);
    chk("mean_px2", log_din(2), 32'hFF);
    chk("mean_latency", (wr_cyc.size() > 0 && pop_cyc.size() > 0) ? 32'(wr_cyc[0] - pop_cyc[0]) : 'x, 32'd2);
    chk("mean_back_to_back", (wr_cyc.size() > 2) ? 32'(wr_cyc[2] - wr_cyc[0]) : 'x, 32'd2);

    // Luma mode directed values
    clear_logs();
    push(24'hFF0000, 1'b1); push(24'h00FF00, 1'b1); push(24'h0000FF, 1'b1); push(24'hFFFFFF, 1'b1);
    drain("luma", 50);
    chk("luma_px0", log_din(0), 32'h4C);
    chk("luma_px1", log_din(1), 32'h95);
    chk("luma_px2", log_din(2), 32'h1C);
    chk("luma_px3", log_din(3), 32'hFF);

    // Backpressure for 5 cycles after the first write
    clear_logs();
    for (int i = 0; i < 8; i++) push(24'($urandom), 1'($urandom));
    n = 0;
    while (wr_log.size() == 0 && n < 20) begin tick(); n++; end
    chk("bp_first_write_in_time", 32'(n < 20), 32'd1);
    out_full = 1'b1;
    #1;
    held = din_a;
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_pop", 32'(rd_a), 32'd0);
      chk("bp_no_write", 32'(wr_a), 32'd0);
      chk("bp_din_stable", 32'(din_a), 32'(held));
      tick();
    end
    out_full = 1'b0;
    drain("bp", 50);
    chk("bp_writes", 32'(wr_log.size()), 32'd8);

    // Mode alternating per pixel on pure red
    clear_logs();
    for (int i = 0; i < 6; i++) push(24'hFF0000, 1'(i % 2));
    drain("alt", 50);
    for (int i = 0; i < 6; i++) begin
      alt_exp = (i % 2 == 0) ? 8'h55 : 8'h4C;
      chk("alt_px", log_din(i), 32'(alt_exp));
    end

    // Frame wrap with FRAME_PIXELS = 4
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    clear_logs();
    for (int i = 0; i < 9; i++) push(24'($urandom), 1'($urandom));
    drain("frame", 60);
    for (int i = 0; i < 9; i++) begin
      chk("frame_done_at_write", log_fd(i), 32'(i == 3 || i == 7));
      chk("pixel_count_at_write", log_pc(i), 32'(i % 4));
    end
    chk("frame_count_after", 32'(pc_a), 32'd1);

    // Reset with two pixels in flight
    clear_logs();
    push(24'h123456, 1'b0); push(24'hABCDEF, 1'b1);
    n = 0;
    while (pop_cyc.size() < 2 && n < 20) begin tick(); n++; end
    chk("flight_pops_in_time", 32'(n < 20), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("flight_no_write", 32'(wr_log.size()), 32'd0);
    chk("flight_pixel_count", 32'(pc_a), 32'd0);
    push(24'h808080, 1'b0);
    drain("flight_new", 20);
    chk("flight_new_write", 32'(wr_log.size()), 32'd1);
    chk("flight_new_px", log_din(0), 32'h80);

    // Random traffic with input gaps and output backpressure
    clear_logs();
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((wr_ptr - rd_ptr) < 6 && $urandom_range(0, 3) != 0) begin
        push(24'($urandom), 1'($urandom));
        pushed++;
      end
      gap      = ($urandom_range(0, 4) == 0);
      out_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain("rand", 200);
    chk("rand_all_written", 32'(wr_log.size()), 32'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
